// File: rtl/joy_pkg.sv
// Shared constants, FSM encoding and counter sizing helper for the joystick debouncer.
package joy_pkg;

    localparam int unsigned JOY_W      = 5;
    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_UP     = 2;
    localparam int unsigned JOY_DOWN   = 3;
    localparam int unsigned JOY_SELECT = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } joy_state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : int'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/joy_debounce_ch.sv
// One joystick channel: 2-flop synchronizer, debounce FSM and auto-repeat timer.
module joy_debounce_ch
    import joy_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 250000,
    parameter int unsigned REPEAT_DLY   = 25000000,
    parameter int unsigned REPEAT_PER   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam int unsigned DB_W    = cnt_w(DEBOUNCE_CNT - 1);
    localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RPT_W   = cnt_w(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 2);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

    logic [1:0]       sync_q, sync_d;
    joy_state_e       state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rpt_q, rpt_d;
    logic             sync;

    assign sync = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], raw};
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        level_d     = level_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        rpt_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync) begin
                    state_d = ST_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                    if (db_cnt_q == DB_LAST) begin
                        state_d     = ST_PRESSED;
                        level_d     = 1'b1;
                        press_d     = 1'b1;
                        rpt_d       = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b0;
                    end
                end
            end
            ST_PRESSED: begin
                if (!sync) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync) begin
                    state_d = ST_PRESSED;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                    if (db_cnt_q == DB_LAST) begin
                        state_d     = ST_IDLE;
                        level_d     = 1'b0;
                        rel_d       = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Auto-repeat runs while held (including a bouncing release) but never on the release edge.
        if ((REPEAT_DLY != 0) && (state_d != ST_IDLE) &&
            ((state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT))) begin
            if ((!rpt_phase_q && (rpt_cnt_q == DLY_LAST)) ||
                ( rpt_phase_q && (rpt_cnt_q == PER_LAST))) begin
                rpt_d       = 1'b1;
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            rpt_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            rpt_q       <= rpt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;
    assign rpt   = rpt_q;

endmodule

// File: rtl/joy_debounce.sv
// Five-channel joystick debouncer with press/release/auto-repeat pulses.
module joy_debounce
    import joy_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 250000,
    parameter int unsigned REPEAT_DLY   = 25000000,
    parameter int unsigned REPEAT_PER   = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             joy_right,
    input  logic             joy_left,
    input  logic             joy_up,
    input  logic             joy_down,
    input  logic             joy_select,
    output logic [JOY_W-1:0] joy_level,
    output logic [JOY_W-1:0] joy_press,
    output logic [JOY_W-1:0] joy_release,
    output logic [JOY_W-1:0] joy_repeat
);

    logic [JOY_W-1:0] raw;

    always_comb begin
        raw             = '0;
        raw[JOY_RIGHT]  = joy_right;
        raw[JOY_LEFT]   = joy_left;
        raw[JOY_UP]     = joy_up;
        raw[JOY_DOWN]   = joy_down;
        raw[JOY_SELECT] = joy_select;
    end

    for (genvar i = 0; i < int'(JOY_W); i++) begin : g_ch
        joy_debounce_ch #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .REPEAT_DLY   (REPEAT_DLY),
            .REPEAT_PER   (REPEAT_PER)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .level (joy_level[i]),
            .press (joy_press[i]),
            .rel   (joy_release[i]),
            .rpt   (joy_repeat[i])
        );
    end

endmodule
